// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 8-bit pipeline: load-use stalls, branch squash,
// data-memory freeze, plus a saturating stall counter and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       id_rs_addr_i,
  input  logic [2:0]       id_rt_addr_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  input  logic             em_memread_i,
  input  logic [2:0]       em_write_addr_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idem_en_o,
  output logic             idem_bubble_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic             mem_timeout_o
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [FW-1:0]    FLUSH_RELOAD = FW'(FLUSH_CYCLES - 1);
  localparam logic [WW-1:0]    WAIT_MAX     = WW'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] STALL_MAX    = '1;

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  state_t           state_reg, state_next;
  logic [FW-1:0]    flush_cnt_reg, flush_cnt_next;
  logic [WW-1:0]    wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             timeout_reg, timeout_next;
  logic             load_use;
  logic             run_rules;
  logic             freeze;

  assign load_use = em_memread_i &
                    ((id_uses_rs_i & (id_rs_addr_i == em_write_addr_i)) |
                     (id_uses_rt_i & (id_rt_addr_i == em_write_addr_i)));

  always_comb begin
    state_next     = (state_reg == MEM_WAIT || state_reg == FLUSH) ? state_reg : RUN;
    flush_cnt_next = flush_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    timeout_next   = timeout_reg;
    pc_en_o        = 1'b1;
    ifid_en_o      = 1'b1;
    idem_en_o      = 1'b1;
    ifid_flush_o   = 1'b0;
    idem_bubble_o  = 1'b0;
    run_rules      = 1'b0;
    freeze         = 1'b0;

    if (state_reg == MEM_WAIT) begin
      if (!mem_ready_i) begin
        freeze = 1'b1;
        if (wait_cnt_reg != WAIT_MAX)
          wait_cnt_next = wait_cnt_reg + WW'(1);
      end else begin
        wait_cnt_next = '0;
        state_next    = RUN;
        run_rules     = 1'b1;
      end
    end else if (mem_req_i && !mem_ready_i) begin
      // Entering a wait drops any pending flush: the frozen IF/ID already holds the NOP.
      freeze         = 1'b1;
      state_next     = MEM_WAIT;
      wait_cnt_next  = WW'(1);
      flush_cnt_next = '0;
    end else if (state_reg == FLUSH) begin
      ifid_flush_o = 1'b1;
      if (branch_taken_i) begin
        flush_cnt_next = FLUSH_RELOAD;
      end else if (flush_cnt_reg == FW'(1)) begin
        flush_cnt_next = '0;
        state_next     = RUN;
      end else begin
        flush_cnt_next = flush_cnt_reg - FW'(1);
      end
    end else begin
      run_rules = 1'b1;
    end

    if (freeze) begin
      pc_en_o   = 1'b0;
      ifid_en_o = 1'b0;
      idem_en_o = 1'b0;
      if (wait_cnt_next == WAIT_MAX)
        timeout_next = 1'b1;
    end

    if (run_rules) begin
      if (branch_taken_i) begin
        ifid_flush_o  = 1'b1;
        idem_bubble_o = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_next     = FLUSH;
          flush_cnt_next = FLUSH_RELOAD;
        end
      end else if (load_use) begin
        pc_en_o       = 1'b0;
        ifid_en_o     = 1'b0;
        idem_bubble_o = 1'b1;
      end
    end

    if (rst_i) begin
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idem_en_o     = 1'b0;
      ifid_flush_o  = 1'b1;
      idem_bubble_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= RUN;
      flush_cnt_reg <= '0;
      wait_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      timeout_reg   <= timeout_next;
      if (!pc_en_o && stall_cnt_reg != STALL_MAX)
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cycles_o = stall_cnt_reg;
  assign mem_timeout_o  = timeout_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl against a cycle-level
// behavioural model of the stall/flush/freeze rules.
module tb_pipeline_hazard_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int MEM_TIMEOUT  = 3;
  localparam int CNT_W        = 6;
  localparam int N_CYCLES     = 1500;
  localparam int STALL_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       id_rs_addr, id_rt_addr, em_write_addr;
  logic             id_uses_rs, id_uses_rt, em_memread;
  logic             branch_taken, mem_req, mem_ready;
  logic             pc_en, ifid_en, ifid_flush, idem_en, idem_bubble;
  logic [CNT_W-1:0] stall_cycles;
  logic             mem_timeout;

  typedef struct {
    int         idx;
    logic [4:0] ctl;   // {pc_en, ifid_en, ifid_flush, idem_en, idem_bubble}
    int         stall;
    logic       tout;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_rs_addr_i   (id_rs_addr),
    .id_rt_addr_i   (id_rt_addr),
    .id_uses_rs_i   (id_uses_rs),
    .id_uses_rt_i   (id_uses_rt),
    .em_memread_i   (em_memread),
    .em_write_addr_i(em_write_addr),
    .branch_taken_i (branch_taken),
    .mem_req_i      (mem_req),
    .mem_ready_i    (mem_ready),
    .pc_en_o        (pc_en),
    .ifid_en_o      (ifid_en),
    .ifid_flush_o   (ifid_flush),
    .idem_en_o      (idem_en),
    .idem_bubble_o  (idem_bubble),
    .stall_cycles_o (stall_cycles),
    .mem_timeout_o  (mem_timeout)
  );

  always #5 clk = ~clk;

  // Model state: whether memory is being waited on, flush cycles still owed
  // after this one, length of the current wait run, stall total, timeout flag.
  bit m_in_wait  = 0;
  int m_flush    = 0;
  int m_wait_run = 0;
  int m_stall    = 0;
  bit m_tout     = 0;

  initial begin
    exp_t e;
    bit   waiting, lu, p, fi, fl, ie, bb;
    rst = 1'b1;
    id_rs_addr = '0; id_rt_addr = '0; em_write_addr = '0;
    id_uses_rs = 0; id_uses_rt = 0; em_memread = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 1;

    for (int n = 0; n < N_CYCLES; n++) begin
      @(posedge clk);
      #1;
      rst           = (n < 3) || ($urandom_range(0, 399) == 0);
      id_rs_addr    = 3'($urandom_range(0, 3));
      id_rt_addr    = 3'($urandom_range(0, 3));
      em_write_addr = 3'($urandom_range(0, 3));
      id_uses_rs    = 1'($urandom_range(0, 1));
      id_uses_rt    = 1'($urandom_range(0, 1));
      em_memread    = 1'($urandom_range(0, 1));
      branch_taken  = ($urandom_range(0, 5) == 0);
      mem_req       = ($urandom_range(0, 3) == 0);
      mem_ready     = ($urandom_range(0, 9) >= 5);

      e.idx   = n;
      e.stall = m_stall;
      e.tout  = m_tout;
      if (rst) begin
        e.ctl      = 5'b00101;
        m_in_wait  = 0;
        m_flush    = 0;
        m_wait_run = 0;
        m_stall    = 0;
        m_tout     = 0;
      end else begin
        p = 1; fi = 1; fl = 0; ie = 1; bb = 0;
        lu = em_memread && ((id_uses_rs && id_rs_addr == em_write_addr) ||
                            (id_uses_rt && id_rt_addr == em_write_addr));
        waiting = m_in_wait ? !mem_ready : (mem_req && !mem_ready);
        if (waiting) begin
          p = 0; fi = 0; ie = 0;
          m_in_wait  = 1;
          m_flush    = 0;
          m_wait_run = m_wait_run + 1;
          if (m_wait_run >= MEM_TIMEOUT) m_tout = 1;
        end else begin
          m_in_wait  = 0;
          m_wait_run = 0;
          if (branch_taken) begin
            fl = 1;
            bb = (m_flush == 0);
            m_flush = FLUSH_CYCLES - 1;
          end else if (m_flush > 0) begin
            fl = 1;
            m_flush = m_flush - 1;
          end else if (lu) begin
            p = 0; fi = 0; bb = 1;
          end
        end
        e.ctl = {p, fi, fl, ie, bb};
        if (!p && m_stall < STALL_MAX) m_stall = m_stall + 1;
      end
      exp_q.push_back(e);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: outputs are settled mid-cycle, so compare on the falling edge.
  initial begin
    exp_t       e;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {pc_en, ifid_en, ifid_flush, idem_en, idem_bubble};
        checks++;
        if (act !== e.ctl) begin
          errors++;
          $display("FAIL ctl txn %0d: got %b required %b", e.idx, act, e.ctl);
        end
        checks++;
        if (int'(stall_cycles) != e.stall || $isunknown(stall_cycles)) begin
          errors++;
          $display("FAIL stall txn %0d: got %0d required %0d", e.idx, stall_cycles, e.stall);
        end
        checks++;
        if (mem_timeout !== e.tout) begin
          errors++;
          $display("FAIL timeout txn %0d: got %b required %b", e.idx, mem_timeout, e.tout);
        end
        $display("txn %0d rst=%b ctl=%b stall=%0d tout=%b", e.idx, rst, act, stall_cycles, mem_timeout);
      end
    end
  end

endmodule
